data_path: RTL and testbench

- Minimal register-transfer datapath: three WIDTH-bit registers (RA, RB, RZ) on one shared bus, plus an adder that adds an immediate to the bus value.
- External control strobes, set by a step sequencer, select one bus driver and the registers that latch each clock.
- Serves as the tutorial-level execution core. Supports ldi, addi via RZ, and register-to-register moves.

---
 rtl/data_path_if.sv | 32 +++
 rtl/data_path.sv | 70 +++++++
 tb/tb_data_path.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/data_path_if.sv
// Bus and strobe bundle between the step sequencer and the datapath.
// master = sequencer side, slave = datapath side.
interface data_path_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] AddImmediate;
   logic [WIDTH-1:0] RegisterAImmediate;
   logic             RZout;
   logic             RAout;
   logic             RBout;
   logic             RAin;
   logic             RBin;
   logic             RZin;
   logic [WIDTH-1:0] RAval;
   logic [WIDTH-1:0] RBval;
   logic [WIDTH-1:0] RZval;
   logic [WIDTH-1:0] BusMuxOut;

   modport master (
      output AddImmediate, RegisterAImmediate,
      output RZout, RAout, RBout,
      output RAin, RBin, RZin,
      input  RAval, RBval, RZval, BusMuxOut
   );

   modport slave (
      input  AddImmediate, RegisterAImmediate,
      input  RZout, RAout, RBout,
      input  RAin, RBin, RZin,
      output RAval, RBval, RZval, BusMuxOut
   );
endinterface

// File: rtl/data_path.sv
// Three-register shared-bus datapath with an immediate adder into RZ.
// Optional carry register enabled by DATAPATH_CARRY_EN.
module data_path #(
   parameter int WIDTH = 8
) (
   input  logic      clock,
   input  logic      clear,
`ifdef DATAPATH_CARRY_EN
   output logic      CarryOut,
`endif
   data_path_if.slave dp
);
   logic [WIDTH-1:0] ra_q, ra_d;
   logic [WIDTH-1:0] rb_q, rb_d;
   logic [WIDTH-1:0] rz_q, rz_d;
   logic [WIDTH-1:0] bus;
   logic [WIDTH:0]   sum;

   // Fixed priority RZ > RA > RB; immediate when nothing drives
   always_comb begin
      bus = dp.RegisterAImmediate;
      if (dp.RZout)
         bus = rz_q;
      else if (dp.RAout)
         bus = ra_q;
      else if (dp.RBout)
         bus = rb_q;
   end

   always_comb begin
      sum  = {1'b0, bus} + {1'b0, dp.AddImmediate};
      ra_d = dp.RAin ? bus : ra_q;
      rb_d = dp.RBin ? bus : rb_q;
      rz_d = dp.RZin ? sum[WIDTH-1:0] : rz_q;
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         ra_q <= '0;
         rb_q <= '0;
         rz_q <= '0;
      end else begin
         ra_q <= ra_d;
         rb_q <= rb_d;
         rz_q <= rz_d;
      end
   end

`ifdef DATAPATH_CARRY_EN
   logic carry_q, carry_d;

   always_comb begin
      carry_d = dp.RZin ? sum[WIDTH] : carry_q;
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear)
         carry_q <= 1'b0;
      else
         carry_q <= carry_d;
   end

   assign CarryOut = carry_q;
`endif

   assign dp.RAval     = ra_q;
   assign dp.RBval     = rb_q;
   assign dp.RZval     = rz_q;
   assign dp.BusMuxOut = bus;
endmodule

// File: tb/tb_data_path.sv
// Self-checking bench for data_path: vector table plus reset corner cases.
module tb_data_path;
   localparam int W = 8;

   logic clock = 1'b0;
   logic clear;
`ifdef DATAPATH_CARRY_EN
   logic carry;
`endif

   data_path_if #(.WIDTH(W)) dpi ();

   data_path #(.WIDTH(W)) dut (
      .clock    (clock),
      .clear    (clear),
`ifdef DATAPATH_CARRY_EN
      .CarryOut (carry),
`endif
      .dp       (dpi.slave)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [5:0]   st;
      logic [W-1:0] imm;
      logic [W-1:0] addi;
      logic [W-1:0] bus;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic [W-1:0] rz;
      logic         c;
   } vec_t;

   typedef struct {
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic [W-1:0] rz;
      logic         c;
   } exp_t;

   vec_t vt[13];
   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // st = {RZout, RAout, RBout, RAin, RBin, RZin}
   task automatic drive(input logic [5:0] st, input logic [W-1:0] imm,
                        input logic [W-1:0] addi);
      {dpi.RZout, dpi.RAout, dpi.RBout,
       dpi.RAin, dpi.RBin, dpi.RZin} = st;
      dpi.RegisterAImmediate = imm;
      dpi.AddImmediate       = addi;
   endtask

   task automatic check_regs(input string nm, input logic [W-1:0] ra,
                             input logic [W-1:0] rb, input logic [W-1:0] rz,
                             input logic c);
      chk({nm, ".ra"}, 32'(dpi.RAval), 32'(ra));
      chk({nm, ".rb"}, 32'(dpi.RBval), 32'(rb));
      chk({nm, ".rz"}, 32'(dpi.RZval), 32'(rz));
`ifdef DATAPATH_CARRY_EN
      chk({nm, ".c"}, 32'(carry), 32'(c));
`else
      if (c === 1'bx) $display("carry expectation undefined in %s", nm);
`endif
   endtask

   task automatic pop_check(input string nm);
      exp_t e;
      if (sb.size() == 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s: scoreboard empty got 0 expected 1", nm);
      end else begin
         e = sb.pop_front();
         check_regs(nm, e.ra, e.rb, e.rz, e.c);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0]  = '{6'b000100, 8'h05, 8'h00, 8'h05, 8'h05, 8'h00, 8'h00, 1'b0};
      vt[1]  = '{6'b010001, 8'h00, 8'h05, 8'h05, 8'h05, 8'h00, 8'h0A, 1'b0};
      vt[2]  = '{6'b100010, 8'h00, 8'h00, 8'h0A, 8'h05, 8'h0A, 8'h0A, 1'b0};
      vt[3]  = '{6'b000100, 8'hF0, 8'h00, 8'hF0, 8'hF0, 8'h0A, 8'h0A, 1'b0};
      vt[4]  = '{6'b000010, 8'h11, 8'h00, 8'h11, 8'hF0, 8'h11, 8'h0A, 1'b0};
      vt[5]  = '{6'b000001, 8'h22, 8'h00, 8'h22, 8'hF0, 8'h11, 8'h22, 1'b0};
      vt[6]  = '{6'b111000, 8'h77, 8'h00, 8'h22, 8'hF0, 8'h11, 8'h22, 1'b0};
      vt[7]  = '{6'b100001, 8'h77, 8'hFF, 8'h22, 8'hF0, 8'h11, 8'h21, 1'b1};
      vt[8]  = '{6'b011010, 8'h77, 8'h00, 8'hF0, 8'hF0, 8'hF0, 8'h21, 1'b1};
      vt[9]  = '{6'b001001, 8'h00, 8'h01, 8'hF0, 8'hF0, 8'hF0, 8'hF1, 1'b0};
      vt[10] = '{6'b000110, 8'h3C, 8'h00, 8'h3C, 8'h3C, 8'h3C, 8'hF1, 1'b0};
      vt[11] = '{6'b010100, 8'h99, 8'h00, 8'h3C, 8'h3C, 8'h3C, 8'hF1, 1'b0};
      vt[12] = '{6'b100001, 8'h99, 8'h0F, 8'hF1, 8'h3C, 8'h3C, 8'h00, 1'b1};

      // reset held with random strobes: registers zero before any edge
      clear = 1'b0;
      drive(6'($urandom), 8'($urandom), 8'($urandom));
      #1;
      check_regs("rst_async", 8'h00, 8'h00, 8'h00, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         drive(6'($urandom) | 6'b000111, 8'($urandom), 8'($urandom));
         @(posedge clock);
         #1;
         check_regs("rst_hold", 8'h00, 8'h00, 8'h00, 1'b0);
      end
      @(negedge clock);
      drive(6'b000000, 8'h00, 8'h00);
      clear = 1'b1;
      @(posedge clock);
      #1;
      check_regs("rst_release", 8'h00, 8'h00, 8'h00, 1'b0);

      for (int i = 0; i < 13; i++) begin
         @(negedge clock);
         drive(vt[i].st, vt[i].imm, vt[i].addi);
         #1;
         chk($sformatf("bus[%0d]", i), 32'(dpi.BusMuxOut), 32'(vt[i].bus));
         sb.push_back('{vt[i].ra, vt[i].rb, vt[i].rz, vt[i].c});
         @(posedge clock);
         #1;
         pop_check($sformatf("vec[%0d]", i));
      end

      // strobe pulse between edges must not load
      @(negedge clock);
      drive(6'b000111, 8'hAA, 8'h01);
      #2;
      drive(6'b000000, 8'h00, 8'h00);
      sb.push_back('{8'h3C, 8'h3C, 8'h00, 1'b1});
      @(posedge clock);
      #1;
      pop_check("glitch");

      // mid-operation reset discards the pending load
      @(negedge clock);
      drive(6'b000111, 8'h55, 8'h01);
      #1;
      clear = 1'b0;
      #1;
      check_regs("rst_mid", 8'h00, 8'h00, 8'h00, 1'b0);
      @(posedge clock);
      #1;
      check_regs("rst_mid_edge", 8'h00, 8'h00, 8'h00, 1'b0);
      @(negedge clock);
      drive(6'b000000, 8'h00, 8'h00);
      clear = 1'b1;
      @(posedge clock);
      #1;
      check_regs("rst_mid_rel", 8'h00, 8'h00, 8'h00, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
